// File: rtl/e203_exu_pkg.sv
// Shared write-back definitions: default widths, the {wdat, rdidx} entry
// type and the occupancy-counter width helper.
package e203_exu_pkg;

  localparam int DEF_XLEN     = 32;
  localparam int DEF_RFIDX_W  = 5;
  localparam int DEF_LP_DEPTH = 2;

  typedef struct packed {
    logic [DEF_XLEN-1:0]    wdat;
    logic [DEF_RFIDX_W-1:0] rdidx;
  } wbck_ent_t;

  // Occupancy must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/e203_exu_wbck_arb_if.sv
// Write-back bus bundle: ALU and long-pipe producers, regfile write port,
// OITF retire pulse and long-pipe FIFO occupancy.
interface e203_exu_wbck_arb_if
  import e203_exu_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int RFIDX_W  = DEF_RFIDX_W,
  parameter int LP_DEPTH = DEF_LP_DEPTH
);

  logic                        alu_wbck_i_valid;
  logic                        alu_wbck_i_ready;
  logic [XLEN-1:0]             alu_wbck_i_wdat;
  logic [RFIDX_W-1:0]          alu_wbck_i_rdidx;
  logic                        longp_wbck_i_valid;
  logic                        longp_wbck_i_ready;
  logic [XLEN-1:0]             longp_wbck_i_wdat;
  logic [RFIDX_W-1:0]          longp_wbck_i_rdidx;
  logic                        rf_wbck_o_ena;
  logic [XLEN-1:0]             rf_wbck_o_wdat;
  logic [RFIDX_W-1:0]          rf_wbck_o_rdidx;
  logic                        oitf_ret_ena;
  logic [cnt_w(LP_DEPTH)-1:0]  lp_cnt;

  modport master (
    output alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx,
    output longp_wbck_i_valid, longp_wbck_i_wdat, longp_wbck_i_rdidx,
    input  alu_wbck_i_ready, longp_wbck_i_ready,
    input  rf_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx, oitf_ret_ena, lp_cnt
  );

  modport slave (
    input  alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx,
    input  longp_wbck_i_valid, longp_wbck_i_wdat, longp_wbck_i_rdidx,
    output alu_wbck_i_ready, longp_wbck_i_ready,
    output rf_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx, oitf_ret_ena, lp_cnt
  );

endinterface

// File: rtl/e203_exu_wbck_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; push is ignored when full,
// pop is ignored when empty. Storage is not cleared on reset.
module e203_exu_wbck_fifo
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37,
  localparam int PTR_W = $clog2(DEPTH) + 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [PTR_W-1:0] o_cnt,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PTR_W-1] != r_rptr[PTR_W-1]) &&
                   (r_wptr[PTR_W-2:0] == r_rptr[PTR_W-2:0]);
  assign o_cnt   = r_wptr - r_rptr;
  assign o_head  = r_mem[r_rptr[PTR_W-2:0]];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= {PTR_W{1'b0}};
      r_rptr <= {PTR_W{1'b0}};
    end else begin
      if (w_push) r_wptr <= r_wptr + {{(PTR_W-1){1'b0}}, 1'b1};
      if (w_pop)  r_rptr <= r_rptr + {{(PTR_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wptr[PTR_W-2:0]] <= i_data;
  end

endmodule

// File: rtl/e203_exu_wbck_arb.sv
// Regfile write-back arbiter: buffered long-pipe results always beat the ALU;
// the selected write and the OITF retire pulse are registered.
module e203_exu_wbck_arb
  import e203_exu_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int RFIDX_W  = DEF_RFIDX_W,
  parameter int LP_DEPTH = DEF_LP_DEPTH
)(
  input  logic                 clk,
  input  logic                 rst,
  e203_exu_wbck_arb_if.slave   bus
);

  localparam int CNT_W = cnt_w(LP_DEPTH);
  localparam int ENT_W = XLEN + RFIDX_W;

  typedef struct packed {
    logic [XLEN-1:0]    wdat;
    logic [RFIDX_W-1:0] rdidx;
  } ent_t;

  ent_t               w_lp_in;
  ent_t               w_head;
  ent_t               w_sel;
  logic [ENT_W-1:0]   w_head_bits;
  logic [CNT_W-1:0]   w_cnt;
  logic               w_full;
  logic               w_empty;
  logic               w_lp_ready;
  logic               w_alu_ready;
  logic               w_lp_push;
  logic               w_pop;
  logic               w_sel_vld;

  logic               r_ena;
  logic [XLEN-1:0]    r_wdat;
  logic [RFIDX_W-1:0] r_rdidx;
  logic               r_ret;

  // Readies derive only from registered occupancy, never from valids.
  assign w_lp_ready  = (w_cnt != CNT_W'(LP_DEPTH));
  assign w_alu_ready = (w_cnt == {CNT_W{1'b0}});
  assign w_lp_push   = bus.longp_wbck_i_valid & w_lp_ready;
  assign w_pop       = ~w_empty;
  assign w_lp_in     = '{wdat: bus.longp_wbck_i_wdat, rdidx: bus.longp_wbck_i_rdidx};
  assign w_head      = ent_t'(w_head_bits);

  e203_exu_wbck_fifo #(.DEPTH(LP_DEPTH), .WIDTH(ENT_W)) u_lp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_lp_push),
    .i_data  (w_lp_in),
    .i_pop   (w_pop),
    .o_head  (w_head_bits),
    .o_cnt   (w_cnt),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_sel     = w_head;
    w_sel_vld = 1'b0;
    if (w_pop) begin
      w_sel_vld = 1'b1;
      w_sel     = w_head;
    end else begin
      w_sel_vld = bus.alu_wbck_i_valid & w_alu_ready;
      w_sel     = '{wdat: bus.alu_wbck_i_wdat, rdidx: bus.alu_wbck_i_rdidx};
    end
  end

  // x0 writes finish their handshake but leave the write port untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ena   <= 1'b0;
      r_wdat  <= {XLEN{1'b0}};
      r_rdidx <= {RFIDX_W{1'b0}};
      r_ret   <= 1'b0;
    end else begin
      r_ena <= w_sel_vld && (w_sel.rdidx != {RFIDX_W{1'b0}});
      r_ret <= w_pop;
      if (w_sel_vld && (w_sel.rdidx != {RFIDX_W{1'b0}})) begin
        r_wdat  <= w_sel.wdat;
        r_rdidx <= w_sel.rdidx;
      end
    end
  end

  assign bus.alu_wbck_i_ready   = w_alu_ready;
  assign bus.longp_wbck_i_ready = w_lp_ready;
  assign bus.rf_wbck_o_ena      = r_ena;
  assign bus.rf_wbck_o_wdat     = r_wdat;
  assign bus.rf_wbck_o_rdidx    = r_rdidx;
  assign bus.oitf_ret_ena       = r_ret;
  assign bus.lp_cnt             = w_cnt;

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Directed vector table plus a queue-modelled long-pipe stream for the
// write-back arbiter (XLEN=32, RFIDX_W=5, LP_DEPTH=2).
module tb_e203_exu_wbck_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  e203_exu_wbck_arb_if #(.XLEN(32), .RFIDX_W(5), .LP_DEPTH(2)) u_if ();

  e203_exu_wbck_arb #(.XLEN(32), .RFIDX_W(5), .LP_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  aidx;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lidx;
    logic [31:0] ldat;
    logic        e_ena;
    logic [4:0]  e_idx;
    logic [31:0] e_dat;
    logic        e_ret;
    logic [1:0]  e_cnt;
    logic        e_ardy;
    logic        e_lrdy;
  } vec_t;

  vec_t vecs[$];
  int checks   = 0;
  int failures = 0;
  int step     = 0;

  task automatic add(input logic r, input logic av, input logic [4:0] ai, input logic [31:0] ad,
                     input logic lv, input logic [4:0] li, input logic [31:0] ld,
                     input logic en, input logic [4:0] ei, input logic [31:0] ed,
                     input logic rt, input logic [1:0] ec, input logic ar, input logic lr);
    vec_t v;
    v = '{r, av, ai, ad, lv, li, ld, en, ei, ed, rt, ec, ar, lr};
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", nm, step, act, exp);
    end
  endtask

  task automatic chk_all(input logic en, input logic [4:0] ei, input logic [31:0] ed,
                         input logic rt, input logic [1:0] ec, input logic ar, input logic lr);
    chk("rf_ena",   {63'd0, u_if.rf_wbck_o_ena}, {63'd0, en});
    chk("rf_rdidx", {59'd0, u_if.rf_wbck_o_rdidx}, {59'd0, ei});
    chk("rf_wdat",  {32'd0, u_if.rf_wbck_o_wdat}, {32'd0, ed});
    chk("oitf_ret", {63'd0, u_if.oitf_ret_ena}, {63'd0, rt});
    chk("lp_cnt",   {62'd0, u_if.lp_cnt}, {62'd0, ec});
    chk("alu_rdy",  {63'd0, u_if.alu_wbck_i_ready}, {63'd0, ar});
    chk("lp_rdy",   {63'd0, u_if.longp_wbck_i_ready}, {63'd0, lr});
  endtask

  task automatic drive(input logic r, input logic av, input logic [4:0] ai, input logic [31:0] ad,
                       input logic lv, input logic [4:0] li, input logic [31:0] ld);
    rst                     = r;
    u_if.alu_wbck_i_valid   = av;
    u_if.alu_wbck_i_rdidx   = ai;
    u_if.alu_wbck_i_wdat    = ad;
    u_if.longp_wbck_i_valid = lv;
    u_if.longp_wbck_i_rdidx = li;
    u_if.longp_wbck_i_wdat  = ld;
  endtask

  logic [36:0] q[$];
  logic [36:0] front;
  logic        m_pop, m_push, m_alu_hs, m_av;
  logic        x_ena;
  logic [4:0]  x_idx;
  logic [31:0] x_dat;
  int          popped;

  initial begin
    //   rst av aidx  adat          lv lidx  ldat        | ena idx   dat            ret cnt   ardy lrdy
    add(1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,        1'b0, 2'd0, 1'b1, 1'b1);
    add(1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,  1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 2'd0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd5,  32'hDEADBEEF, 1'b0, 2'd0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h11, 1'b0, 5'd5,  32'hDEADBEEF, 1'b0, 2'd1, 1'b0, 1'b1);
    add(1'b0, 1'b1, 5'd4,  32'h44,       1'b0, 5'd0,  32'h0,  1'b1, 5'd3,  32'h11,       1'b1, 2'd0, 1'b1, 1'b1);
    add(1'b0, 1'b1, 5'd4,  32'h44,       1'b0, 5'd0,  32'h0,  1'b1, 5'd4,  32'h44,       1'b0, 2'd0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd4,  32'h44,       1'b0, 2'd0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  32'hA1, 1'b0, 5'd4,  32'h44,       1'b0, 2'd1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd2,  32'hA2, 1'b1, 5'd1,  32'hA1,       1'b1, 2'd1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'hA3, 1'b1, 5'd2,  32'hA2,       1'b1, 2'd1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 5'd3,  32'hA3,       1'b1, 2'd0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd3,  32'hA3,       1'b0, 2'd0, 1'b1, 1'b1);
    add(1'b0, 1'b1, 5'd0,  32'h55,       1'b0, 5'd0,  32'h0,  1'b0, 5'd3,  32'hA3,       1'b0, 2'd0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h66, 1'b0, 5'd3,  32'hA3,       1'b0, 2'd1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd3,  32'hA3,       1'b1, 2'd0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd3,  32'hA3,       1'b0, 2'd0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h77, 1'b0, 5'd3,  32'hA3,       1'b0, 2'd1, 1'b0, 1'b1);
    add(1'b1, 1'b1, 5'd9,  32'h99,       1'b1, 5'd8,  32'h88, 1'b0, 5'd0,  32'h0,        1'b0, 2'd0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,        1'b0, 2'd0, 1'b1, 1'b1);
    add(1'b0, 1'b1, 5'd10, 32'hAA,       1'b1, 5'd11, 32'hBB, 1'b1, 5'd10, 32'hAA,       1'b0, 2'd1, 1'b0, 1'b1);
    add(1'b0, 1'b1, 5'd12, 32'hCC,       1'b0, 5'd0,  32'h0,  1'b1, 5'd11, 32'hBB,       1'b1, 2'd0, 1'b1, 1'b1);
    add(1'b0, 1'b1, 5'd12, 32'hCC,       1'b0, 5'd0,  32'h0,  1'b1, 5'd12, 32'hCC,       1'b0, 2'd0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd12, 32'hCC,       1'b0, 2'd0, 1'b1, 1'b1);

    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      step = i;
      drive(vecs[i].rst, vecs[i].av, vecs[i].aidx, vecs[i].adat,
            vecs[i].lv, vecs[i].lidx, vecs[i].ldat);
      @(posedge clk);
      #1;
      chk_all(vecs[i].e_ena, vecs[i].e_idx, vecs[i].e_dat, vecs[i].e_ret,
              vecs[i].e_cnt, vecs[i].e_ardy, vecs[i].e_lrdy);
    end

    // Continuous long-pipe stream with an ALU request competing at the start.
    x_idx  = 5'd12;
    x_dat  = 32'hCC;
    m_av   = 1'b1;
    popped = 0;
    for (int c = 0; c < 24; c++) begin
      step = 100 + c;
      drive(1'b0, m_av, 5'd20, 32'hA1A1A1A1, (c < 20), 5'((c % 31) + 1), 32'h1000 + 32'(c));
      m_pop    = (q.size() > 0);
      m_push   = (c < 20) && (q.size() != 2);
      m_alu_hs = m_av && (q.size() == 0);
      front    = m_pop ? q[0] : 37'd0;
      @(posedge clk);
      #1;
      x_ena = 1'b0;
      if (m_pop) begin
        void'(q.pop_front());
        popped++;
        if (front[4:0] != 5'd0) begin
          x_ena = 1'b1;
          x_idx = front[4:0];
          x_dat = front[36:5];
        end
      end else if (m_alu_hs) begin
        x_ena = 1'b1;
        x_idx = 5'd20;
        x_dat = 32'hA1A1A1A1;
        m_av  = 1'b0;
      end
      if (m_push) q.push_back({32'h1000 + 32'(c), 5'((c % 31) + 1)});
      chk_all(x_ena, x_idx, x_dat, m_pop, 2'(q.size()), (q.size() == 0), (q.size() != 2));
    end
    chk("stream_count", 64'(popped), 64'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
